// File: rtl/asyn_re_fsm1.sv
// asyn_re_fsm1: two-state Moore FSM; toggles between A and B on in=0, holds on in=1.
module asyn_re_fsm1 (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic out
);
  typedef enum logic {A = 1'b0, B = 1'b1} state_t;
  state_t state, state_nxt;
  always_ff @(posedge clk) state <= reset ? B : state_nxt;
  always_comb state_nxt = in ? state : (state == A ? B : A);
  assign out = (state == B);
endmodule

// File: tb/tb_asyn_re_fsm1.sv
// tb_asyn_re_fsm1: directed vectors plus hand-written reset and between-edge sequences.
module tb_asyn_re_fsm1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in = 1'b1;
  logic out;
  int n_tests = 0;
  int n_fail = 0;
  typedef struct packed {
    logic rst;
    logic i;
    logic o;
  } vec_t;
  vec_t vecs[$];
  asyn_re_fsm1 dut (.clk(clk), .reset(reset), .in(in), .out(out));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: out=%b expected=%b at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step(input logic r, input logic i);
    @(negedge clk);
    reset = r;
    in = i;
    @(posedge clk);
    #1;
  endtask
  initial begin
    // reset, then hold B with in=1
    vecs.push_back('{1'b1, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 1'b1});
    // B -> A, then hold A
    vecs.push_back('{1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0});
    // A -> B -> A
    vecs.push_back('{1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b0});
    // back to B, then six in=0 edges
    vecs.push_back('{1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1});
    // into A for the mid-operation reset
    vecs.push_back('{1'b0, 1'b0, 1'b0});
    for (int k = 0; k < vecs.size(); k++) begin
      step(vecs[k].rst, vecs[k].i);
      chk($sformatf("vec%0d", k), out, vecs[k].o);
    end
    @(negedge clk);
    reset = 1'b1;
    in = 1'b0;
    #2;
    chk("reset_before_edge", out, 1'b0);
    @(posedge clk);
    #1;
    chk("reset_after_edge", out, 1'b1);
    step(1'b0, 1'b1);
    chk("reset_release_in1", out, 1'b1);
    // wiggle in between edges: registered output must not move
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      in = ~in;
      #1;
      chk($sformatf("between_edges%0d", k), out, 1'b1);
    end
    in = 1'b1;
    step(1'b0, 1'b0);
    chk("after_wiggle_toggle", out, 1'b0);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      in = ~in;
      #1;
      chk($sformatf("between_edges_a%0d", k), out, 1'b0);
    end
    step(1'b0, 1'b1);
    chk("hold_a", out, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/asyn_re_fsm1.md
Name: asyn_re_fsm1

Overview:
- Two-state Moore state machine with a single-bit input `in` and a single-bit output `out`.
- State B is the reset state. The state toggles on every clock edge where `in`=0 and holds on every edge where `in`=1.
- `out` is 1 in state B and 0 in state A.
- Small control/sequence-detect primitive; a reference FSM building block for larger control logic.

Parameters:
- None.

Ports:
- clk    input   1  system clock; all state updates on rising edge
- reset  input   1  synchronous, active-high reset; forces state B on the next rising clk edge
- in     input   1  control input sampled on rising clk edge
- out    output  1  Moore output: 1 when state = B, 0 when state = A

Behaviour:
- One clock; reset is synchronous and active-high. Reset is sampled only on the rising edge of clk; there is no asynchronous path.
- States: A and B. Encoding is free (1 flop sufficient); the recommended encoding is A=0, B=1.
- Reset value: state = B, so `out` = 1 after the first rising edge with reset=1.
- Next-state rules, evaluated at each rising clk edge when reset=0:
  - B, in=1 -> B
  - B, in=0 -> A
  - A, in=1 -> A
  - A, in=0 -> B
- Reset has priority over `in`. If reset=1 at an edge, the next state is B regardless of `in` and the current state.
- Output:
  - `out` is a pure function of the registered state (Moore), with no combinational path from `in` to `out`.
  - `out` changes only after a rising clk edge, with 1-cycle latency from the sampled `in`.
- Reset mid-operation: asserting reset while in A yields B on the next edge; `out` goes 1 on that edge, not before.
- Deasserting reset: the first edge with reset=0 applies the normal transition from B using the `in` sampled at that edge.
- No X-propagation tolerance is required before the first reset edge. A simulation-only initial state of B is permitted.
- Next-state logic and output decode must be fully specified for all encodings (default branch -> B) to avoid latches or stuck states.

Test Plan:
1. Hold reset=1, in=1 for one rising edge, then deassert. Required: `out`=1. With in=1 over 2 further edges, `out` stays 1.
2. From B, apply in=0 at one edge. Required: `out` becomes 0 after that edge (state A). Then in=1 for 2 edges: `out` stays 0.
3. From A, apply in=0 at one edge. Required: `out` becomes 1 (state B). Apply in=0 again at the next edge: `out` returns to 0.
4. Continuous in=0 for 6 edges starting from B. Required: `out` sequence after each edge is 0,1,0,1,0,1.
5. In state A (`out`=0), assert reset=1 with in=0 for one edge. Required: `out`=1 after that edge. Check that `out` does not change before the edge (synchronous reset). Deassert with in=1: `out` stays 1.
6. Change `in` between clock edges without an edge occurring. Required: `out` unchanged, confirming Moore and registered behaviour.
